// File: rtl/hist_pkg.sv
// Shared constants and FSM encoding for the histogram read-out / center tracking block.
package hist_pkg;

  localparam int NUM_BINS   = 32;
  localparam int BIN_W      = 5;
  localparam int COUNT_W    = 20;
  localparam int CENTER_W   = 14;
  localparam int TOTAL_W    = 25;
  localparam int CENTER_MAX = (1 << CENTER_W) - 1;

  localparam logic [BIN_W-1:0] CENTER_BIN = BIN_W'(15);
  localparam logic [BIN_W-1:0] OVF_LO_BIN = BIN_W'(0);
  localparam logic [BIN_W-1:0] OVF_HI_BIN = BIN_W'(NUM_BINS - 1);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_SETTLE = 5'b00010,
    S_SWEEP  = 5'b00100,
    S_DRAIN  = 5'b01000,
    S_UPDATE = 5'b10000
  } state_t;

  // Move the center by the peak's offset from the middle bin, clamped to the center range.
  function automatic logic [CENTER_W-1:0] center_step(input logic [CENTER_W-1:0] c,
                                                      input logic [BIN_W-1:0] bin);
    int s;
    s = int'(c) + int'(bin) - int'(CENTER_BIN);
    if (s < 0) return '0;
    else if (s > CENTER_MAX) return CENTER_W'(CENTER_MAX);
    else return CENTER_W'(s);
  endfunction

endpackage

// File: rtl/hist_peak_acc.sv
// Tag-aligned datapath: pairs each RAM read sample with its address, sums all bins
// and tracks the first strictly-largest bin among the non-overflow bins.
module hist_peak_acc
  import hist_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               issue_valid,
  input  logic [BIN_W-1:0]   issue_addr,
  input  logic [COUNT_W-1:0] q_a,
  output logic               last_sample,
  output logic [TOTAL_W-1:0] total,
  output logic [BIN_W-1:0]   peak_bin,
  output logic [COUNT_W-1:0] peak_count
);

  logic             tag_v [RD_LAT];
  logic [BIN_W-1:0] tag_a [RD_LAT];
  logic             samp_v;
  logic [BIN_W-1:0] samp_a;
  logic             in_window;

  assign samp_v      = tag_v[RD_LAT-1];
  assign samp_a      = tag_a[RD_LAT-1];
  assign in_window   = (samp_a != OVF_LO_BIN) && (samp_a != OVF_HI_BIN);
  assign last_sample = samp_v && (samp_a == OVF_HI_BIN);

  // The tag leaves the last stage in the same cycle its RAM data appears on q_a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_a[i] <= '0;
      end
    end else begin
      tag_v[0] <= issue_valid;
      tag_a[0] <= issue_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_a[i] <= tag_a[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total      <= '0;
      peak_bin   <= CENTER_BIN;
      peak_count <= '0;
    end else if (clear) begin
      total      <= '0;
      peak_bin   <= CENTER_BIN;
      peak_count <= '0;
    end else if (samp_v) begin
      total <= total + TOTAL_W'(q_a);
      // Strictly greater keeps the lowest bin on ties.
      if (in_window && (q_a > peak_count)) begin
        peak_bin   <= samp_a;
        peak_count <= q_a;
      end
    end
  end

endmodule

// File: rtl/hist_reader.sv
// Histogram read-out controller: on a trigger, pauses the writer, sweeps all bins,
// finds the peak and nudges center_val toward it. start/filled are only sampled in IDLE.
module hist_reader
  import hist_pkg::*;
#(
  parameter int RD_LAT       = 2,
  parameter int SETTLE       = 2,
  parameter int MIN_COUNT    = 64,
  parameter int INIT_CENTER  = 8192,
  parameter int AUTO_ON_FULL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                filled,
  input  logic [COUNT_W-1:0]  q_a,
  output logic                pause,
  output logic [BIN_W-1:0]    rdaddr,
  output logic [CENTER_W-1:0] center_val,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    peak_bin,
  output logic [COUNT_W-1:0]  peak_count,
  output logic [TOTAL_W-1:0]  total
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state, state_next;
  logic [SC_W-1:0]  settle_cnt, settle_cnt_next;
  logic [BIN_W-1:0] rdaddr_next;
  logic             trigger;
  logic             clear;
  logic             do_update;
  logic             last_sample;

  assign trigger = start | ((AUTO_ON_FULL != 0) & filled);

  // Decoded from the state register so reset drops pause without waiting for a clock.
  assign pause = (state != S_IDLE);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      rdaddr     <= '0;
      done       <= 1'b0;
      center_val <= CENTER_W'(INIT_CENTER);
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      rdaddr     <= rdaddr_next;
      done       <= do_update;
      if (do_update && (peak_count >= COUNT_W'(MIN_COUNT)))
        center_val <= center_step(center_val, peak_bin);
    end
  end

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    rdaddr_next     = rdaddr;
    clear           = 1'b0;
    do_update       = 1'b0;
    unique case (state)
      S_IDLE: begin
        rdaddr_next = '0;
        if (trigger) begin
          clear           = 1'b1;
          settle_cnt_next = '0;
          state_next      = (SETTLE == 0) ? S_SWEEP : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SC_W'(SETTLE - 1)) state_next = S_SWEEP;
        else settle_cnt_next = settle_cnt + SC_W'(1);
      end
      S_SWEEP: begin
        if (rdaddr == OVF_HI_BIN) state_next = S_DRAIN;
        else rdaddr_next = rdaddr + BIN_W'(1);
      end
      S_DRAIN: begin
        // Leave once the final bin's sample is being folded into the accumulator.
        if (last_sample) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        do_update  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  hist_peak_acc #(
    .RD_LAT(RD_LAT)
  ) u_peak_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .issue_valid(state == S_SWEEP),
    .issue_addr (rdaddr),
    .q_a        (q_a),
    .last_sample(last_sample),
    .total      (total),
    .peak_bin   (peak_bin),
    .peak_count (peak_count)
  );

endmodule

// File: tb/tb_hist_reader.sv
// Directed bench for hist_reader: table of single-sweep vectors plus multi-cycle sequences.
module tb_hist_reader;
  import hist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, start_hi = 1'b0, start_lo = 1'b0, filled = 1'b0;
  logic [19:0] mem [32];

  logic [19:0] q_a, q_hi, q_lo, p_a, p_hi, p_lo;
  logic        pause, busy, done, pause_hi, busy_hi, done_hi, pause_lo, busy_lo, done_lo;
  logic [4:0]  rdaddr, rdaddr_hi, rdaddr_lo, peak_bin, peak_bin_hi, peak_bin_lo;
  logic [13:0] center_val, center_hi, center_lo;
  logic [19:0] peak_count, peak_count_hi, peak_count_lo;
  logic [24:0] total, total_hi, total_lo;

  // Two-stage RAM read model per DUT.
  always @(posedge clk) begin
    p_a  <= mem[rdaddr];    q_a  <= p_a;
    p_hi <= mem[rdaddr_hi]; q_hi <= p_hi;
    p_lo <= mem[rdaddr_lo]; q_lo <= p_lo;
  end

  hist_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filled(filled), .q_a(q_a),
    .pause(pause), .rdaddr(rdaddr), .center_val(center_val), .busy(busy), .done(done),
    .peak_bin(peak_bin), .peak_count(peak_count), .total(total));

  hist_reader #(.INIT_CENTER(16380)) dut_hi (
    .clk(clk), .rst_n(rst_n), .start(start_hi), .filled(1'b0), .q_a(q_hi),
    .pause(pause_hi), .rdaddr(rdaddr_hi), .center_val(center_hi), .busy(busy_hi), .done(done_hi),
    .peak_bin(peak_bin_hi), .peak_count(peak_count_hi), .total(total_hi));

  hist_reader #(.INIT_CENTER(5)) dut_lo (
    .clk(clk), .rst_n(rst_n), .start(start_lo), .filled(1'b0), .q_a(q_lo),
    .pause(pause_lo), .rdaddr(rdaddr_lo), .center_val(center_lo), .busy(busy_lo), .done(done_lo),
    .peak_bin(peak_bin_lo), .peak_count(peak_count_lo), .total(total_lo));

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    int b0, c0, b1, c1, b2, c2;
    int pb, pc, tot, ctr;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic dsel(input int which);
    return (which == 0) ? done : (which == 1) ? done_hi : done_lo;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  // Trigger is sampled on the posedge between the two negedges.
  task automatic fire(input int which);
    @(negedge clk);
    if (which == 0) start = 1'b1; else if (which == 1) start_hi = 1'b1; else start_lo = 1'b1;
    @(negedge clk);
    start = 1'b0; start_hi = 1'b0; start_lo = 1'b0;
  endtask

  // Called just after the trigger edge (edge 1); returns the edge count at which done was seen.
  task automatic wait_done(input int which, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 1;
    while (!seen && lat < 100) begin
      @(posedge clk); lat++; #1;
      seen = dsel(which);
    end
    check("done_seen", {31'b0, seen}, 1);
    if (seen) begin
      @(posedge clk); #1;
      check("done_one_cycle", {31'b0, dsel(which)}, 0);
    end
  endtask

  int lat;
  int base;

  initial begin
    vecs[0] = '{20, 500,    0, 0,       0, 0,       20, 500, 500,     8197};
    vecs[1] = '{3,  100,    27, 100,    31, 10000,  3,  100, 10200,   8180};
    vecs[2] = '{30, 40,     0, 0,       0, 0,       30, 40,  40,      8192};
    vecs[3] = '{0,  0,      0, 0,       0, 0,       15, 0,   0,       8192};
    vecs[4] = '{0, 1048575, 31, 1048575, 15, 64,    15, 64,  2097214, 8192};
    vecs[5] = '{10, 63,     0, 0,       0, 0,       10, 63,  63,      8192};
    vecs[6] = '{1,  64,     2, 65,      30, 65,     2,  65,  194,     8179};
    clear_mem();

    // Reset and idle.
    do_reset();
    repeat (10) @(negedge clk);
    check("idle_center", 32'(center_val), 8192);
    check("idle_pause", 32'(pause), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_rdaddr", 32'(rdaddr), 0);
    check("idle_peak_bin", 32'(peak_bin), 15);
    check("idle_total", 32'(total), 0);
    check("idle_no_done", done_cnt, 0);

    // Table: one sweep per row from a fresh reset.
    for (int r = 0; r < 7; r++) begin
      do_reset();
      clear_mem();
      mem[vecs[r].b0] = 20'(vecs[r].c0);
      mem[vecs[r].b1] = 20'(vecs[r].c1);
      mem[vecs[r].b2] = 20'(vecs[r].c2);
      fire(0);
      check("row_busy", 32'(busy), 1);
      check("row_pause", 32'(pause), 1);
      wait_done(0, lat);
      check("row_latency", lat, 38);
      check("row_peak_bin", 32'(peak_bin), vecs[r].pb);
      check("row_peak_count", 32'(peak_count), vecs[r].pc);
      check("row_total", 32'(total), vecs[r].tot);
      check("row_center", 32'(center_val), vecs[r].ctr);
      check("row_pause_after", 32'(pause), 0);
      check("row_busy_after", 32'(busy), 0);
    end

    // Back-to-back sweeps accumulate; a start while busy is dropped.
    do_reset();
    clear_mem();
    mem[20] = 20'd500;
    base = done_cnt;
    fire(0);
    for (int i = 0; i < 60 && rdaddr != 5'd10; i++) @(negedge clk);
    check("reach_addr10", 32'(rdaddr), 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    check("busy_start_center", 32'(center_val), 8197);
    repeat (50) @(negedge clk);
    check("busy_start_no_queue", done_cnt - base, 1);
    check("busy_start_idle", 32'(busy), 0);
    fire(0);
    wait_done(0, lat);
    check("second_sweep_center", 32'(center_val), 8202);

    // Trigger in the UPDATE cycle is ignored.
    do_reset();
    fire(0);
    repeat (36) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check("update_cycle_done", 32'(done), 1);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("update_trigger_ignored", 32'(busy), 0);

    // filled held high retriggers on return to IDLE.
    do_reset();
    @(negedge clk);
    filled = 1'b1;
    @(negedge clk);
    wait_done(0, lat);
    check("filled_latency", lat, 38);
    check("filled_retrigger_busy", 32'(busy), 1);
    @(negedge clk);
    filled = 1'b0;
    wait_done(0, lat);
    check("filled_second_latency", lat, 38);
    check("filled_center", 32'(center_val), 8202);

    // Reset mid-sweep aborts with no update.
    do_reset();
    fire(0);
    wait_done(0, lat);
    check("pre_abort_center", 32'(center_val), 8197);
    fire(0);
    for (int i = 0; i < 60 && rdaddr != 5'd17; i++) @(negedge clk);
    check("reach_addr17", 32'(rdaddr), 17);
    rst_n = 1'b0;
    #1;
    check("abort_pause", 32'(pause), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_center", 32'(center_val), 8192);
    check("abort_peak_count", 32'(peak_count), 0);
    check("abort_total", 32'(total), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    check("abort_center_hold", 32'(center_val), 8192);

    // Saturation at both ends of the center range.
    do_reset();
    clear_mem();
    mem[30] = 20'd1000;
    fire(1);
    wait_done(1, lat);
    check("sat_hi_peak_bin", 32'(peak_bin_hi), 30);
    check("sat_hi_center", 32'(center_hi), 16383);
    clear_mem();
    mem[1] = 20'd100;
    fire(2);
    wait_done(2, lat);
    check("sat_lo_peak_bin", 32'(peak_bin_lo), 1);
    check("sat_lo_center", 32'(center_lo), 0);
    check("sat_default_untouched", 32'(center_val), 8192);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
